// File: rtl/loadstore_pkg.sv
// loadstore_pkg: encodings shared by the load/store control unit, its decoder
// and the downstream datapath (ADD_SUB / OP_MEM select values).
package loadstore_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_LD_SD = 3'b011;
  localparam logic [2:0] F3_ADDI  = 3'b000;

  localparam logic ADD_SUB_ADD = 1'b0;
  localparam logic ADD_SUB_SUB = 1'b1;
  localparam logic OP_MEM_ALU  = 1'b0;
  localparam logic OP_MEM_MEM  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LD   = 2'd0,
    OP_SD   = 2'd1,
    OP_ADDI = 2'd2
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] offset;
    logic       add_sub;
    logic       illegal;
  } dec_t;

  // Datapath offset is a 5-bit magnitude, so only -31..+31 is representable.
  function automatic logic imm_in_range(input logic [11:0] imm);
    return ($signed(imm) >= -12'sd31) && ($signed(imm) <= 12'sd31);
  endfunction

endpackage

// File: rtl/loadstore_dec.sv
// loadstore_dec: combinational decode of one instruction word.
//   instr : 32-bit instruction
//   dec   : op, rs1, rs2 (SD only, else 0), rd (LD/ADDI only, else 0),
//           sign/magnitude offset and illegal flag
module loadstore_dec
  import loadstore_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [11:0] imm;
  logic        legal_op;
  logic        neg;

  always_comb begin
    opc      = instr[6:0];
    f3       = instr[14:12];
    imm      = instr[31:20];
    legal_op = 1'b0;
    dec      = '0;
    dec.op   = OP_LD;
    dec.rs1  = instr[19:15];

    if (opc == OPC_LOAD && f3 == F3_LD_SD) begin
      dec.op   = OP_LD;
      dec.rd   = instr[11:7];
      legal_op = 1'b1;
    end else if (opc == OPC_STORE && f3 == F3_LD_SD) begin
      dec.op   = OP_SD;
      dec.rs2  = instr[24:20];
      imm      = {instr[31:25], instr[11:7]};
      legal_op = 1'b1;
    end else if (opc == OPC_OPIMM && f3 == F3_ADDI) begin
      dec.op   = OP_ADDI;
      dec.rd   = instr[11:7];
      legal_op = 1'b1;
    end

    neg = imm[11];
    // Negation modulo 32 only needs the low five bits; range check covers the rest.
    dec.offset  = neg ? (~imm[4:0] + 5'd1) : imm[4:0];
    dec.add_sub = neg ? ADD_SUB_SUB : ADD_SUB_ADD;
    dec.illegal = !legal_op || !imm_in_range(imm);
  end

endmodule

// File: rtl/loadstore_uc.sv
// loadstore_uc: multicycle control unit for the load/store datapath.
//   clk, reset           : clock, synchronous active-high reset
//   instr/instr_valid    : instruction offer; instr_ready high only in IDLE
//   Ra/Rb/Rw             : register bank addresses (rs1, rs2 for SD, rd)
//   WE_reg/WE_mem        : register bank / memory write enables
//   OFFSET/ADD_SUB       : offset magnitude and add/subtract select
//   OP_MEM               : writeback mux select (1 = memory data)
//   done/illegal         : one-cycle retire / reject pulses
//   retired              : wrapping count of retired instructions
module loadstore_uc
  import loadstore_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [4:0]       Ra,
  output logic [4:0]       Rb,
  output logic [4:0]       Rw,
  output logic             WE_reg,
  output logic             WE_mem,
  output logic [4:0]       OFFSET,
  output logic             OP_MEM,
  output logic             ADD_SUB,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  op_t    op_r;
  logic   ill_r;
  dec_t   dec;

  loadstore_dec u_dec (
    .instr (instr),
    .dec   (dec)
  );

  assign instr_ready = (state == ST_IDLE) && !reset;

  // Outputs are registered for the state being entered, so each state's
  // controls are visible during that state's own cycle. The decoded fields
  // are captured at the accept edge instead of the raw instruction word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_r    <= OP_LD;
      ill_r   <= 1'b0;
      Ra      <= '0;
      Rb      <= '0;
      Rw      <= '0;
      WE_reg  <= 1'b0;
      WE_mem  <= 1'b0;
      OFFSET  <= '0;
      OP_MEM  <= OP_MEM_ALU;
      ADD_SUB <= ADD_SUB_ADD;
      done    <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      WE_reg  <= 1'b0;
      WE_mem  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_r    <= dec.op;
            ill_r   <= dec.illegal;
            Ra      <= dec.rs1;
            Rb      <= dec.rs2;
            Rw      <= dec.rd;
            OFFSET  <= dec.offset;
            ADD_SUB <= dec.add_sub;
            OP_MEM  <= (dec.op == OP_LD) ? OP_MEM_MEM : OP_MEM_ALU;
            illegal <= dec.illegal;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= ill_r ? ST_IDLE : ST_ADDR;
        end
        ST_ADDR: begin
          if (op_r == OP_ADDI) begin
            state   <= ST_WB;
            WE_reg  <= (Rw != 5'd0);
            done    <= 1'b1;
            retired <= retired + CNT_W'(1);
          end else begin
            state <= ST_MEM;
            if (op_r == OP_SD) begin
              WE_mem  <= 1'b1;
              done    <= 1'b1;
              retired <= retired + CNT_W'(1);
            end
          end
        end
        ST_MEM: begin
          if (op_r == OP_SD) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_WB;
            WE_reg  <= (Rw != 5'd0);
            done    <= 1'b1;
            retired <= retired + CNT_W'(1);
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loadstore_uc.sv
module tb_loadstore_uc;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;

  logic        instr_ready, WE_reg, WE_mem, OP_MEM, ADD_SUB, done, illegal;
  logic [4:0]  Ra, Rb, Rw, OFFSET;
  logic [15:0] retired;

  logic        s_ready, s_we_reg, s_we_mem, s_op_mem, s_add_sub, s_done, s_illegal;
  logic [4:0]  s_ra, s_rb, s_rw, s_offset;
  logic [2:0]  s_retired;

  loadstore_uc #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Ra(Ra), .Rb(Rb), .Rw(Rw), .WE_reg(WE_reg),
    .WE_mem(WE_mem), .OFFSET(OFFSET), .OP_MEM(OP_MEM), .ADD_SUB(ADD_SUB),
    .done(done), .illegal(illegal), .retired(retired)
  );

  // Narrow counter instance so wrap-around is reached quickly.
  loadstore_uc #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(s_ready), .Ra(s_ra), .Rb(s_rb), .Rw(s_rw), .WE_reg(s_we_reg),
    .WE_mem(s_we_mem), .OFFSET(s_offset), .OP_MEM(s_op_mem), .ADD_SUB(s_add_sub),
    .done(s_done), .illegal(s_illegal), .retired(s_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  // ---------------- behavioural model ----------------
  // An accepted instruction occupies m_lat cycles (1 = reject, 3 = SD/ADDI,
  // 4 = LD); m_age counts which of those cycles is current, 0 means idle.
  int          m_age = 0;
  int          m_lat = 0;
  int          m_kind = 0;
  logic        m_legal = 1'b0;
  logic        known = 1'b1;
  logic [4:0]  e_ra = '0, e_rb = '0, e_rw = '0, e_off = '0;
  logic        e_as = 1'b0, e_om = 1'b0;
  logic [31:0] m_ret = '0;

  task automatic model_accept(input logic [31:0] ins);
    logic [11:0] ib;
    int imm;
    int kind;
    ib = '0;
    if (ins[6:0] == 7'h03 && ins[14:12] == 3'd3) begin
      kind = 0; ib = ins[31:20];
    end else if (ins[6:0] == 7'h23 && ins[14:12] == 3'd3) begin
      kind = 1; ib = {ins[31:25], ins[11:7]};
    end else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
      kind = 2; ib = ins[31:20];
    end else begin
      kind = -1;
    end
    imm = (int'(ib) >= 2048) ? int'(ib) - 4096 : int'(ib);
    m_legal = (kind >= 0) && (imm >= -31) && (imm <= 31);
    m_age = 1;
    if (m_legal) begin
      m_kind = kind;
      known  = 1'b1;
      e_ra   = ins[19:15];
      e_rb   = (kind == 1) ? ins[24:20] : 5'd0;
      e_rw   = (kind == 1) ? 5'd0 : ins[11:7];
      e_off  = (imm < 0) ? 5'(-imm) : 5'(imm);
      e_as   = (imm < 0);
      e_om   = (kind == 0);
      m_lat  = (kind == 0) ? 4 : 3;
    end else begin
      known = 1'b0;
      m_lat = 1;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_age = 0; m_lat = 0; m_legal = 1'b0; known = 1'b1; m_ret = '0;
      e_ra = '0; e_rb = '0; e_rw = '0; e_off = '0; e_as = 1'b0; e_om = 1'b0;
    end else if (m_age == 0) begin
      if (instr_valid) model_accept(instr);
    end else if (m_age == m_lat) begin
      m_age = 0;
    end else begin
      m_age++;
    end
    if (!reset && m_legal && m_age != 0 && m_age == m_lat) m_ret++;
  end

  task automatic check_outputs(input string tag,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rw, input logic [4:0] off,
                               input logic as, input logic om, input logic wer,
                               input logic wem, input logic dn, input logic ill,
                               input logic rdy, input logic [31:0] ret_act,
                               input logic [31:0] ret_exp);
    logic e_done;
    e_done = m_legal && m_age != 0 && m_age == m_lat;
    check({tag, ".done"},    {31'd0, dn},  {31'd0, e_done});
    check({tag, ".illegal"}, {31'd0, ill}, {31'd0, (!m_legal && m_age == 1)});
    check({tag, ".WE_mem"},  {31'd0, wem}, {31'd0, (e_done && m_kind == 1)});
    check({tag, ".WE_reg"},  {31'd0, wer}, {31'd0, (e_done && m_kind != 1 && e_rw != 5'd0)});
    check({tag, ".ready"},   {31'd0, rdy}, {31'd0, (m_age == 0 && !reset)});
    check({tag, ".retired"}, ret_act, ret_exp);
    if (known) begin
      check({tag, ".Ra"},      {27'd0, ra},  {27'd0, e_ra});
      check({tag, ".Rb"},      {27'd0, rb},  {27'd0, e_rb});
      check({tag, ".Rw"},      {27'd0, rw},  {27'd0, e_rw});
      check({tag, ".OFFSET"},  {27'd0, off}, {27'd0, e_off});
      check({tag, ".ADD_SUB"}, {31'd0, as},  {31'd0, e_as});
      check({tag, ".OP_MEM"},  {31'd0, om},  {31'd0, e_om});
    end
  endtask

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      check_outputs("main", Ra, Rb, Rw, OFFSET, ADD_SUB, OP_MEM, WE_reg, WE_mem,
                    done, illegal, instr_ready, {16'd0, retired}, m_ret & 32'hFFFF);
      check_outputs("small", s_ra, s_rb, s_rw, s_offset, s_add_sub, s_op_mem, s_we_reg,
                    s_we_mem, s_done, s_illegal, s_ready, {29'd0, s_retired}, m_ret & 32'h7);
    end
  end

  // ---------------- directed helpers ----------------
  int         r_done, r_ill, r_wer, r_wem, r_wer_n, r_wem_n, r_ready;
  logic [4:0] f_ra, f_rb, f_rw, f_off;
  logic       f_as, f_om;

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!instr_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic [31:0] ins);
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    r_done = 0; r_ill = 0; r_wer = 0; r_wem = 0; r_wer_n = 0; r_wem_n = 0; r_ready = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        f_ra = Ra; f_rb = Rb; f_rw = Rw; f_off = OFFSET; f_as = ADD_SUB; f_om = OP_MEM;
      end
      if (done && r_done == 0) r_done = c;
      if (illegal && r_ill == 0) r_ill = c;
      if (WE_reg) begin r_wer_n++; if (r_wer == 0) r_wer = c; end
      if (WE_mem) begin r_wem_n++; if (r_wem == 0) r_wem = c; end
      if (instr_ready && r_ready == 0) r_ready = c;
      instr_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    int          imm;
    logic [11:0] ib;
    logic [4:0]  r1, r2, rd;
    k   = int'($urandom % 6);
    imm = int'($urandom_range(0, 80)) - 40;
    ib  = 12'(imm);
    r1  = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
    case (k)
      0, 1:    return i_type(ib, r1, 3'd3, rd, 7'h03);
      2:       return s_type(ib, r2, r1);
      3:       return i_type(ib, r1, 3'd0, rd, 7'h13);
      4:       return i_type(ib, r1, 3'($urandom), rd, 7'h03);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  int d_cnt;
  int d_at [3];

  initial begin
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst.ready",   {31'd0, instr_ready}, 32'd0);
    check("rst.retired", {16'd0, retired}, 32'd0);
    check("rst.Ra",      {27'd0, Ra}, 32'd0);
    check("rst.done",    {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // LD x5, 12(x2)
    run_one(32'h00C13283);
    check("ld.done_cyc", r_done, 4);
    check("ld.wer_cyc",  r_wer, 4);
    check("ld.wer_n",    r_wer_n, 1);
    check("ld.wem_n",    r_wem_n, 0);
    check("ld.Ra",       {27'd0, f_ra}, 2);
    check("ld.Rb",       {27'd0, f_rb}, 0);
    check("ld.Rw",       {27'd0, f_rw}, 5);
    check("ld.OFFSET",   {27'd0, f_off}, 12);
    check("ld.ADD_SUB",  {31'd0, f_as}, 0);
    check("ld.OP_MEM",   {31'd0, f_om}, 1);
    check("ld.ready",    r_ready, 5);
    check("ld.retired",  {16'd0, retired}, 1);

    // SD x7, -8(x3)
    run_one(s_type(12'hFF8, 5'd7, 5'd3));
    check("sd.done_cyc", r_done, 3);
    check("sd.wem_cyc",  r_wem, 3);
    check("sd.wem_n",    r_wem_n, 1);
    check("sd.wer_n",    r_wer_n, 0);
    check("sd.Ra",       {27'd0, f_ra}, 3);
    check("sd.Rb",       {27'd0, f_rb}, 7);
    check("sd.OFFSET",   {27'd0, f_off}, 8);
    check("sd.ADD_SUB",  {31'd0, f_as}, 1);
    check("sd.retired",  {16'd0, retired}, 2);

    // ADDI x0, x1, 5
    run_one(i_type(12'd5, 5'd1, 3'd0, 5'd0, 7'h13));
    check("addi0.done_cyc", r_done, 3);
    check("addi0.wer_n",    r_wer_n, 0);
    check("addi0.retired",  {16'd0, retired}, 3);

    // ADDI x4, x1, 31
    run_one(i_type(12'd31, 5'd1, 3'd0, 5'd4, 7'h13));
    check("addi4.done_cyc", r_done, 3);
    check("addi4.wer_cyc",  r_wer, 3);
    check("addi4.OP_MEM",   {31'd0, f_om}, 0);
    check("addi4.OFFSET",   {27'd0, f_off}, 31);
    check("addi4.Rw",       {27'd0, f_rw}, 4);
    check("addi4.retired",  {16'd0, retired}, 4);

    // Illegal: imm 40, imm -32, funct3 010
    run_one(i_type(12'd40, 5'd2, 3'd3, 5'd5, 7'h03));
    check("ill40.ill_cyc", r_ill, 1);
    check("ill40.done",    r_done, 0);
    check("ill40.we",      r_wer_n + r_wem_n, 0);
    check("ill40.ready",   r_ready, 2);
    run_one(i_type(12'hFE0, 5'd2, 3'd3, 5'd5, 7'h03));
    check("illm32.ill_cyc", r_ill, 1);
    check("illm32.done",    r_done, 0);
    check("illm32.ready",   r_ready, 2);
    run_one(i_type(12'd4, 5'd2, 3'd2, 5'd5, 7'h03));
    check("illf3.ill_cyc", r_ill, 1);
    check("illf3.we",      r_wer_n + r_wem_n, 0);
    check("illf3.ready",   r_ready, 2);
    check("ill.retired",   {16'd0, retired}, 4);

    // Back-to-back LDs with instr_valid held high
    wait_ready();
    instr = 32'h00C13283;
    instr_valid = 1'b1;
    d_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done) begin
        if (d_cnt < 3) d_at[d_cnt] = c;
        d_cnt++;
      end
      if (c == 15) instr_valid = 1'b0;
    end
    check("b2b.count",   d_cnt, 3);
    check("b2b.done0",   d_at[0], 4);
    check("b2b.done1",   d_at[1], 9);
    check("b2b.done2",   d_at[2], 14);
    check("b2b.retired", {16'd0, retired}, 7);
    check("b2b.small",   {29'd0, s_retired}, 7);

    // One more retire wraps the 3-bit counter
    run_one(i_type(12'd1, 5'd1, 3'd0, 5'd3, 7'h13));
    check("wrap.small", {29'd0, s_retired}, 0);

    // Reset during the MEM cycle of an LD
    wait_ready();
    instr = 32'h00C13283;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst.WE_reg",  {31'd0, WE_reg}, 0);
    check("mrst.done",    {31'd0, done}, 0);
    check("mrst.Ra",      {27'd0, Ra}, 0);
    check("mrst.OFFSET",  {27'd0, OFFSET}, 0);
    check("mrst.ready",   {31'd0, instr_ready}, 0);
    check("mrst.retired", {16'd0, retired}, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mrst.after_WE_reg", {31'd0, WE_reg}, 0);
      check("mrst.after_ready",  {31'd0, instr_ready}, 1);
    end

    // Randomized traffic, including valid while busy and sporadic resets
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset       = ($urandom % 250) == 0;
      instr_valid = ($urandom % 3) != 0;
      instr       = rand_instr();
    end
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Any asserted write enables must never overlap.
  always @(negedge clk) begin
    #2;
    if (cmp_en) check("we_exclusive", {31'd0, (WE_reg && WE_mem)}, 32'd0);
  end

endmodule
